// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one single-port synchronous ROM (one-cycle read latency) between
//   two requesters: port 0 (instruction fetch) and port 1 (data load).
//   Each port owns a one-entry response slot. The slot cycles through
//   EMPTY -> PENDING (read issued) -> FULL (data captured). A port may only
//   be granted while its slot is EMPTY, or while it is FULL and being
//   drained in the same cycle, so each port has at most one read in flight.
//   Ties between the two ports are broken round-robin.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/addr/ready     request channel for port N (ready = grant)
//   rspN_valid/data/ready     response channel for port N (valid = slot FULL)
//   rom_addr                  address to the ROM, 0 when nothing is granted
//   rom_data                  ROM output, valid the cycle after the address
module rom_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_FULL    = 2'd2
    } slot_t;

    // Per-port views of the two channels so the slot logic can be generated.
    logic [1:0]             req_valid;
    logic [1:0]             rsp_ready;
    logic [1:0]             eligible;
    logic [1:0]             grant;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_W-1:0] rsp_data;

    // Port that won the most recent grant; reset to 1 so port 0 wins the first tie.
    logic last_grant_reg;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            slot_t             slot_reg;
            logic [DATA_W-1:0] data_reg;

            // A FULL slot can take a new grant only when its current word is
            // being consumed in the same cycle. Gated by rst so nothing is
            // accepted while reset is held.
            assign eligible[gi] = !rst && req_valid[gi] &&
                                  ((slot_reg == SLOT_EMPTY) ||
                                   ((slot_reg == SLOT_FULL) && rsp_ready[gi]));

            assign rsp_valid[gi] = (slot_reg == SLOT_FULL);
            assign rsp_data[gi]  = data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= SLOT_EMPTY;
                    data_reg <= '0;
                end else begin
                    case (slot_reg)
                        SLOT_EMPTY: begin
                            if (grant[gi])
                                slot_reg <= SLOT_PENDING;
                        end
                        SLOT_PENDING: begin
                            // The ROM word for this port's read is on rom_data
                            // now; at most one port can be PENDING at a time.
                            slot_reg <= SLOT_FULL;
                            data_reg <= rom_data;
                        end
                        SLOT_FULL: begin
                            // A grant here implies a drain (see eligibility).
                            if (grant[gi])
                                slot_reg <= SLOT_PENDING;
                            else if (rsp_ready[gi])
                                slot_reg <= SLOT_EMPTY;
                        end
                        default: slot_reg <= SLOT_EMPTY;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin: on a tie, the port opposite the last winner is granted.
    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11)
            grant = last_grant_reg ? 2'b01 : 2'b10;
        else
            grant = eligible;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant_reg <= 1'b1;
        else if (grant[0])
            last_grant_reg <= 1'b0;
        else if (grant[1])
            last_grant_reg <= 1'b1;
    end

    always_comb begin
        rom_addr = '0;
        if (grant[0])
            rom_addr = req0_addr;
        else if (grant[1])
            rom_addr = req1_addr;
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
//   Drives both ports of rom_arbiter against a behavioural ROM whose word k
//   is 32'h1000_0000 + k. Every accepted request pushes its expected word
//   into a per-port queue; every consumed response pops and compares.
//   Outputs are sampled on the falling edge, inputs change 1 time unit after
//   the rising edge.
module tb_rom_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [31:0] ROM_BASE = 32'h1000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              rsp0_ready, rsp1_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    // Behavioural synchronous ROM, one-cycle read latency.
    always @(posedge clk)
        rom_data <= ROM_BASE + {27'd0, rom_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
                else                    check("rsp0_data", rsp0_data, exp_q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
                else                    check("rsp1_data", rsp1_data, exp_q1.pop_front());
            end
            if (req0_valid && req0_ready) exp_q0.push_back(ROM_BASE + {27'd0, req0_addr});
            if (req1_valid && req1_ready) exp_q1.push_back(ROM_BASE + {27'd0, req1_addr});
        end
    end

    // Issue n reads on port p at addresses base, base+step, ... (mod 32),
    // holding each request until it is accepted.
    task automatic drive_port(input int p, input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            int waited;
            a = ADDR_W'(base + i * step);
            if (p == 0) begin req0_valid = 1'b1; req0_addr = a; end
            else        begin req1_valid = 1'b1; req1_addr = a; end
            waited = 0;
            forever begin
                @(negedge clk);
                if ((p == 0) ? req0_ready : req1_ready) break;
                waited++;
                if (waited > 40) begin
                    check("drv_accept_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int waited;
        logic prev_g;
        logic [ADDR_W-1:0] prev_a;

        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd6;
        req1_valid = 1'b1; req1_addr = 5'd7;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset defaults with both requests asserted.
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rsp0_data", rsp0_data, 0);
        check("rst_rsp1_data", rsp1_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First tie after reset goes to port 0.
        fork
            drive_port(0, 1, 6, 0);
            drive_port(1, 1, 7, 0);
            begin
                @(negedge clk);
                check("tie_req0_ready", req0_ready, 1);
                check("tie_req1_ready", req1_ready, 0);
                check("tie_rom_addr", rom_addr, 6);
            end
        join
        idle(4);

        // Single read on port 0, response two edges after acceptance.
        fork
            drive_port(0, 1, 5, 0);
            begin
                waited = 0;
                forever begin
                    @(negedge clk);
                    if (req0_ready) break;
                    waited++;
                    if (waited > 20) begin check("single_accept_timeout", 0, 1); break; end
                end
                @(negedge clk);
                check("single_rsp_e", rsp0_valid, 0);
                check("single_ready_once", req0_ready, 0);
                @(negedge clk);
                check("single_rsp_e1", rsp0_valid, 1);
                check("single_data", rsp0_data, ROM_BASE + 32'd5);
            end
        join
        idle(4);

        // Continuous contention: grants alternate, ROM address moves every cycle.
        fork
            drive_port(0, 8, 0, 1);
            drive_port(1, 8, 31, -1);
            begin
                prev_g = 1'b0;
                prev_a = '0;
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    check("cont_one_grant", req0_ready ^ req1_ready, 1);
                    if (k > 0) begin
                        check("cont_alternate", req1_ready, !prev_g);
                        check("cont_addr_change", rom_addr != prev_a, 1);
                    end
                    prev_g = req1_ready;
                    prev_a = rom_addr;
                end
            end
        join
        idle(4);

        // Backpressure on port 1 while port 0 keeps reading.
        rsp1_ready = 1'b0;
        drive_port(1, 1, 3, 0);
        waited = 0;
        while (!rsp1_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("bp_rsp1_valid", rsp1_valid, 1);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_addr = 5'd4;
        cnt = 0;
        fork
            drive_port(0, 4, 10, 1);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("bp_hold_data", rsp1_data, ROM_BASE + 32'd3);
                check("bp_req1_ready", req1_ready, 0);
                if (req0_ready) cnt++;
            end
        join
        check("bp_p0_grants", cnt, 4);
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp_regrant", req1_ready, 1);
        check("bp_regrant_addr", rom_addr, 4);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        idle(4);

        // Reset while port 1 is PENDING: that read never responds.
        req1_valid = 1'b1; req1_addr = 5'd9;
        waited = 0;
        forever begin
            @(negedge clk);
            if (req1_ready) break;
            waited++;
            if (waited > 20) begin check("midrst_accept_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        req1_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_rsp1_in_rst", rsp1_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_rsp1_after", rsp1_valid, 0);
        end
        check("midrst_rsp1_data", rsp1_data, 0);
        @(posedge clk); #1;
        drive_port(1, 1, 2, 0);
        idle(4);

        // Address wrap on port 0: 31 then 0.
        drive_port(0, 2, 31, 1);
        idle(6);

        check("sb_q0_empty", exp_q0.size(), 0);
        check("sb_q1_empty", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter that shares the single-port synchronous program ROM (32 x 32-bit, one-cycle read latency) between the instruction-fetch port (port 0) and the data-load port (port 1). Each port has a valid/ready request channel and a valid/ready response channel with a one-entry response buffer. Arbitration is round-robin, and one ROM read issues per cycle. The block sits between the core's fetch/load units and the `rom` instance.

## Interface
- `ADDR_W`, default 5: ROM word-address width.
- `DATA_W`, default 32: ROM word width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  port 0 read request.
- `req0_addr`  in  ADDR_W  port 0 word address.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `rsp0_valid`  out  1  port 0 response data valid.
- `rsp0_data`  out  DATA_W  port 0 read data.
- `rsp0_ready`  in  1  port 0 consumer takes the response.
- `req1_*` / `rsp1_*`: same as port 0, for port 1.
- `rom_addr`  out  ADDR_W  address to the ROM, sampled by the ROM on the rising edge.
- `rom_data`  in  DATA_W  ROM output, valid the cycle after the address edge.

## Operation
- **Per-port slot FSM** (states EMPTY, PENDING, FULL):
  - EMPTY -> PENDING on grant.
  - PENDING -> FULL unconditionally on the next edge; `rom_data` is captured into `rspN_data`.
  - FULL -> EMPTY on `rspN_valid & rspN_ready` with no new grant.
  - FULL -> PENDING on a drain and a grant in the same cycle.
- **Eligibility:** port N is eligible when `reqN_valid & (slot==EMPTY | (slot==FULL & rspN_ready))`. A PENDING port is never eligible, so each port has at most one read in flight.
- **Arbitration:**
  - One eligible port: it is granted.
  - Both eligible: grant the port opposite `last_grant`.
  - `last_grant` updates to the granted port on every grant.
- **Outputs:**
  - `reqN_ready` = grant to port N (combinational; it may depend on `reqN_valid`).
  - `rom_addr` = address of the granted port; 0 when there is no grant.
- **Requester rules:** `reqN_addr` must stay stable while `reqN_valid` is high and `reqN_ready` is low. A requester must not drop `reqN_valid` before acceptance; the arbiter does not check this.
- **Response channel:**
  - `rspN_valid` = (slot==FULL).
  - `rspN_data` holds its value until the response is consumed.
- **Throughput:**
  - Aggregate: one ROM read per cycle when both ports alternate.
  - Single port: one read per 2 cycles, because it is ineligible while PENDING.
- **Response order:** responses per port come back in request order (trivially, with one request outstanding).

## Timing
- **Reset values (asynchronous assert):**
  - All slots EMPTY; any in-flight read is discarded.
  - `rsp0_valid` = `rsp1_valid` = 0; `rsp0_data` = `rsp1_data` = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `reqN_ready` = 0 and `rom_addr` = 0 while `rst` is high.
- **Latency:** a request accepted at edge E has `rspN_valid` = 1 after edge E+1. That is 2 edges from handshake to response.
- **Back-to-back consumption:** a FULL slot with `rspN_ready` = 1 and `reqN_valid` = 1 drains and re-grants in the same cycle. The new data appears 2 edges later, leaving a 1-cycle `rspN_valid` gap.
- **Backpressure:** while a slot is FULL and `rspN_ready` = 0, `reqN_ready` = 0. The other port continues unaffected.
- **Reset mid-operation:**
  - Reset asserted while a port is PENDING: no response is produced for that read.
  - After `rst` deasserts, the next accepted request behaves as the first after reset.
- **Same address on both ports:** there is no conflict. Reads are serviced on consecutive cycles in round-robin order, and both ports return the same word.

## Test plan
The bench ROM image is word k = 32'h1000_0000 + k.
- **Reset defaults:** assert `rst` with both `reqN_valid` = 1 -> `reqN_ready` = 0, `rspN_valid` = 0, `rom_addr` = 0. After deassert, the first tie grants port 0.
- **Single read, port 0:** `req0_addr` = 5, `rsp0_ready` = 1 -> `req0_ready` = 1 for one cycle; `rsp0_valid` = 1 with `rsp0_data` = 32'h1000_0005 two edges after acceptance.
- **Continuous contention:** both ports request constantly, port 0 at addresses 0..7 and port 1 at addresses 31..24 -> grants alternate 0,1,0,1. `rom_addr` changes every cycle. Every returned word equals 32'h1000_0000 + addr, in order per port.
- **Backpressure:** hold `rsp1_ready` = 0 after one port-1 read of address 3 -> `rsp1_data` = 32'h1000_0003 stays stable and `req1_ready` = 0. Port 0 meanwhile completes reads every 2 cycles. Releasing `rsp1_ready` re-grants port 1 in that cycle.
- **Reset mid-flight:** assert `rst` the cycle after port 1 is accepted at address 9 -> `rsp1_valid` never rises for that read. After deassert, a read of address 2 returns 32'h1000_0002.
- **Address wrap:** a port-0 read of address 31 followed by address 0 -> returns 32'h1000_001F, then 32'h1000_0000.
